// File: rtl/fpu_ctrl_pkg.sv
// Shared opcode, state and constant definitions for the FP issue sequencer.
package fpu_ctrl_pkg;

  typedef enum logic [3:0] {
    FNEG  = 4'd0,
    FABS  = 4'd1,
    FADD  = 4'd2,
    FSUB  = 4'd3,
    FMUL  = 4'd4,
    FDIV  = 4'd5,
    FSQRT = 4'd6
  } fop_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PIPE_WAIT = 2'd1,
    ITER_WAIT = 2'd2,
    RESP      = 2'd3
  } state_e;

  localparam logic [31:0] FP_QNAN  = 32'h7fc00000;

  localparam logic [1:0]  PSEL_ADD = 2'd0;
  localparam logic [1:0]  PSEL_SUB = 2'd1;
  localparam logic [1:0]  PSEL_MUL = 2'd2;

endpackage

// File: rtl/fpu_sign_unit.sv
// Combinational sign manipulation: fneg flips bit 31, fabs clears it; all other bits pass.
module fpu_sign_unit (
  input  logic        abs_sel,
  input  logic [31:0] x,
  output logic [31:0] y
);

  always_comb begin
    y = abs_sel ? {1'b0, x[30:0]} : {~x[31], x[30:0]};
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Single-issue FP sequencer: sign ops inline, add/sub/mul to the pipelined unit,
// div/sqrt to the iterative unit, one tagged response per accepted op.
module fpu_issue_ctrl
  import fpu_ctrl_pkg::*;
#(
  parameter int PIPE_LAT = 2,
  parameter int ITER_MAX = 64,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic             pipe_start,
  output logic [1:0]       pipe_sel,
  output logic [31:0]      pipe_x,
  output logic [31:0]      pipe_y,
  input  logic [31:0]      pipe_result,
  output logic             iter_start,
  output logic             iter_sel,
  output logic [31:0]      iter_x,
  output logic [31:0]      iter_y,
  input  logic             iter_done,
  input  logic [31:0]      iter_result,
  output logic             busy
);

  localparam int CNT_MAX = (PIPE_LAT > ITER_MAX) ? PIPE_LAT : ITER_MAX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PIPE_LAT_C = CNT_W'(PIPE_LAT);
  localparam logic [CNT_W-1:0] ITER_MAX_C = CNT_W'(ITER_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [31:0]      x_q, x_d;
  logic [31:0]      y_q, y_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      result_q, result_d;
  logic             err_q, err_d;
  logic             pipe_start_q, pipe_start_d;
  logic             iter_start_q, iter_start_d;
  logic [31:0]      sign_res;

  fpu_sign_unit u_sign (
    .abs_sel (in_op == FABS),
    .x       (in_x),
    .y       (sign_res)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    x_d          = x_q;
    y_d          = y_q;
    tag_d        = tag_q;
    result_d     = result_q;
    err_d        = err_q;
    pipe_start_d = 1'b0;
    iter_start_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d  = in_op;
          x_d   = in_x;
          y_d   = in_y;
          tag_d = in_tag;
          err_d = 1'b0;
          case (in_op)
            FNEG, FABS: begin
              result_d = sign_res;
              state_d  = RESP;
            end
            FADD, FSUB, FMUL: begin
              pipe_start_d = 1'b1;
              cnt_d        = PIPE_LAT_C;
              state_d      = PIPE_WAIT;
            end
            FDIV, FSQRT: begin
              iter_start_d = 1'b1;
              cnt_d        = '0;
              state_d      = ITER_WAIT;
            end
            default: begin
              result_d = FP_QNAN;
              err_d    = 1'b1;
              state_d  = RESP;
            end
          endcase
        end
      end

      // Down-counter hits zero exactly in the cycle the pipelined result is valid.
      PIPE_WAIT: begin
        if (cnt_q == '0) begin
          result_d = pipe_result;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      // Done takes priority over timeout, including in the start cycle.
      ITER_WAIT: begin
        if (iter_done) begin
          result_d = iter_result;
          state_d  = RESP;
        end else if (cnt_q == ITER_MAX_C) begin
          result_d = FP_QNAN;
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      RESP: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      tag_q        <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
      pipe_start_q <= 1'b0;
      iter_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tag_q        <= tag_d;
      result_q     <= result_d;
      err_q        <= err_d;
      pipe_start_q <= pipe_start_d;
      iter_start_q <= iter_start_d;
    end
  end

  // Operand/opcode holding registers only matter while an op is in flight.
  always_ff @(posedge clk) begin
    op_q <= op_d;
    x_q  <= x_d;
    y_q  <= y_d;
  end

  always_comb begin
    pipe_sel = PSEL_ADD;
    case (op_q)
      FSUB:    pipe_sel = PSEL_SUB;
      FMUL:    pipe_sel = PSEL_MUL;
      default: pipe_sel = PSEL_ADD;
    endcase
  end

  assign in_ready   = (state_q == IDLE) && !rst;
  assign out_valid  = (state_q == RESP);
  assign out_result = result_q;
  assign out_tag    = tag_q;
  assign out_err    = err_q;
  assign busy       = (state_q != IDLE);
  assign pipe_start = pipe_start_q;
  assign pipe_x     = x_q;
  assign pipe_y     = y_q;
  assign iter_start = iter_start_q;
  assign iter_sel   = (op_q == FSQRT);
  assign iter_x     = x_q;
  assign iter_y     = y_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Randomized self-checking bench for fpu_issue_ctrl against a latency/result reference model.
module tb_fpu_issue_ctrl;

  localparam int PIPE_LAT = 2;
  localparam int ITER_MAX = 64;
  localparam int TAG_W    = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [31:0]      in_x, in_y;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;
  logic             pipe_start;
  logic [1:0]       pipe_sel;
  logic [31:0]      pipe_x, pipe_y;
  logic [31:0]      pipe_result;
  logic             iter_start;
  logic             iter_sel;
  logic [31:0]      iter_x, iter_y;
  logic             iter_done;
  logic [31:0]      iter_result;
  logic             busy;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  fpu_issue_ctrl #(.PIPE_LAT(PIPE_LAT), .ITER_MAX(ITER_MAX), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_x(in_x), .in_y(in_y), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_err(out_err),
    .pipe_start(pipe_start), .pipe_sel(pipe_sel), .pipe_x(pipe_x), .pipe_y(pipe_y),
    .pipe_result(pipe_result),
    .iter_start(iter_start), .iter_sel(iter_sel), .iter_x(iter_x), .iter_y(iter_y),
    .iter_done(iter_done), .iter_result(iter_result),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: expected cycles from accept to out_valid, result and error flag.
  // d = cycles after iter_start at which iter_done pulses (-1 = never).
  task automatic model(input logic [3:0] op, input logic [31:0] x, input int d,
                       input logic [31:0] unit_res,
                       output int lat, output logic [31:0] res, output logic err);
    err = 1'b0;
    if (op == 4'd0) begin
      lat = 1; res = x ^ 32'h8000_0000;
    end else if (op == 4'd1) begin
      lat = 1; res = x & 32'h7fff_ffff;
    end else if (op >= 4'd2 && op <= 4'd4) begin
      lat = 2 + PIPE_LAT; res = unit_res;
    end else if (op == 4'd5 || op == 4'd6) begin
      if (d >= 0 && d <= ITER_MAX) begin
        lat = 2 + d; res = unit_res;
      end else begin
        lat = 2 + ITER_MAX; res = 32'h7fc0_0000; err = 1'b1;
      end
    end else begin
      lat = 1; res = 32'h7fc0_0000; err = 1'b1;
    end
  endtask

  // Entered and left at a negedge with the DUT idle.
  task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [TAG_W-1:0] tag, input int d, input logic [31:0] unit_res,
                        input int bp, output int vcyc);
    int exp_lat, k;
    logic [31:0] exp_res;
    logic exp_err, seen, is_pipe, is_iter;
    model(op, x, d, unit_res, exp_lat, exp_res, exp_err);
    is_pipe = (op >= 4'd2 && op <= 4'd4);
    is_iter = (op == 4'd5 || op == 4'd6);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_op = op; in_x = x; in_y = y; in_tag = tag;
    out_ready = (bp == 0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_x = $urandom; in_y = $urandom; in_op = 4'($urandom);
    k = 0; seen = 1'b0;
    while (!seen && k < ITER_MAX + 8) begin
      @(negedge clk); k++;
      pipe_result = (is_pipe && k == 1 + PIPE_LAT) ? unit_res : $urandom;
      iter_done   = is_iter ? (d >= 0 && k == 1 + d) : ($urandom_range(0, 3) == 0);
      iter_result = (is_iter && k == 1 + d) ? unit_res : $urandom;
      if (k == 1) begin
        chk("pipe_start", 32'(pipe_start), 32'(is_pipe));
        chk("iter_start", 32'(iter_start), 32'(is_iter));
      end else if (k <= 3) begin
        chk("pipe_start_pulse", 32'(pipe_start), 32'd0);
        chk("iter_start_pulse", 32'(iter_start), 32'd0);
      end
      if (is_pipe && k <= 1 + PIPE_LAT) begin
        chk("pipe_x", pipe_x, x);
        chk("pipe_y", pipe_y, y);
        chk("pipe_sel", 32'(pipe_sel), 32'(op) - 32'd2);
      end
      if (is_iter && (k == 1 || k == exp_lat - 1)) begin
        chk("iter_x", iter_x, x);
        chk("iter_y", iter_y, y);
        chk("iter_sel", 32'(iter_sel), 32'(op == 4'd6));
      end
      if (out_valid) seen = 1'b1;
    end
    iter_done = 1'b0;
    vcyc = cyc;
    chk("latency", 32'(k), 32'(exp_lat));
    chk("result", out_result, exp_res);
    chk("tag", 32'(out_tag), 32'(tag));
    chk("err", 32'(out_err), 32'(exp_err));
    chk("busy_resp", 32'(busy), 32'd1);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      iter_done = ($urandom_range(0, 1) == 1);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_result", out_result, exp_res);
      chk("bp_tag", 32'(out_tag), 32'(tag));
      chk("bp_err", 32'(out_err), 32'(exp_err));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    iter_done = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_hs_valid", 32'(out_valid), 32'd0);
    chk("post_hs_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int v0, v1, lat, d, bp, r;
    logic [3:0] op;
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_x = '0; in_y = '0; in_tag = '0;
    out_ready = 1'b1; pipe_result = '0; iter_done = 1'b0; iter_result = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pipe_start", 32'(pipe_start), 32'd0);
    chk("rst_iter_start", 32'(iter_start), 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op(4'd0, 32'h3f80_0000, 32'h0, 5'd3, -1, 32'h0, 0, v0);
    run_op(4'd0, 32'h0000_0000, 32'h0, 5'd7, -1, 32'h0, 0, v0);
    run_op(4'd1, 32'h8000_0000, 32'h0, 5'd8, -1, 32'h0, 0, v1);
    chk("b2b_spacing", 32'(v1 - v0), 32'd2);
    run_op(4'd1, 32'hffc0_1234, 32'h0, 5'd9, -1, 32'h0, 0, v0);
    run_op(4'd4, 32'h4000_0000, 32'h4040_0000, 5'd11, -1, 32'h40c0_0000, 0, v0);
    run_op(4'd5, 32'h3f80_0000, 32'h4000_0000, 5'd12, 10, 32'h3f00_0000, 0, v0);
    run_op(4'd5, 32'h3f80_0000, 32'h0, 5'd13, -1, 32'h1234_5678, 0, v0);
    run_op(4'd6, 32'h4080_0000, 32'h0, 5'd14, 0, 32'h4000_0000, 0, v0);
    run_op(4'd6, 32'h4080_0000, 32'h0, 5'd15, ITER_MAX, 32'h4000_0000, 0, v0);
    run_op(4'd5, 32'h4080_0000, 32'h0, 5'd16, ITER_MAX + 1, 32'h4000_0000, 0, v0);
    run_op(4'd15, 32'h1111_1111, 32'h2222_2222, 5'd17, -1, 32'h0, 5, v0);
    run_op(4'd2, 32'h3f80_0000, 32'h3f80_0000, 5'd18, -1, 32'h4000_0000, 3, v0);

    // Reset while in PIPE_WAIT
    in_valid = 1'b1; in_op = 4'd4; in_x = 32'h4000_0000; in_y = 32'h4000_0000; in_tag = 5'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1; #1;
    chk("in_ready_in_rst", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      pipe_result = 32'h4080_0000;
      iter_done = 1'b1;
      @(negedge clk);
      chk("late_valid", 32'(out_valid), 32'd0);
      chk("late_busy", 32'(busy), 32'd0);
    end
    iter_done = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      op = (r <= 6) ? 4'(r) : 4'($urandom_range(7, 15));
      d  = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 15);
      bp = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      model(op, 32'h0, d, 32'h0, lat, v1[31:0], r[0]);
      run_op(op, $urandom, $urandom, 5'($urandom), d, $urandom, bp, v0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
